// File: rtl/transmit_arbiter_pkg.sv
// Shared types and constants for the transmit arbiter: FSM states and frame geometry.
package transmit_arbiter_pkg;

    localparam int FRAME_W           = 64;
    localparam int ARB_START_TIMEOUT = 64;

    typedef enum logic [1:0] {
        ARB_IDLE      = 2'd0,
        ARB_LAUNCH    = 2'd1,
        ARB_WAIT_DONE = 2'd2
    } arb_state_t;

endpackage

// File: rtl/transmit_arbiter_rr_priority_select.sv
// Combinational round-robin selector: first asserted request at or after ptr, wrapping.
module rr_priority_select #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic               valid,
    output logic [IDX_W-1:0]   idx
);

    int cand;

    // Walk offsets from farthest to nearest so the nearest set request wins.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        cand  = 0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            cand = (int'(ptr) + i) % NUM_REQ;
            if (req[cand]) begin
                valid = 1'b1;
                idx   = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/transmit_arbiter.sv
// Round-robin arbiter sharing one data_transmitter among NUM_REQ frame producers.
module transmit_arbiter
    import transmit_arbiter_pkg::*;
#(
    parameter int NUM_REQ       = 4,
    parameter int IDX_W         = 2,
    parameter int START_TIMEOUT = ARB_START_TIMEOUT
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*FRAME_W-1:0] req_data,
    output logic [NUM_REQ-1:0]         grant,
    output logic [NUM_REQ-1:0]         done,
    output logic                       error,
    output logic [IDX_W-1:0]           owner,
    output logic                       tx_send,
    output logic [FRAME_W-1:0]         tx_data,
    input  logic                       tx_busy
);

    localparam int CNT_W = $clog2(START_TIMEOUT) + 1;

    arb_state_t           state, state_d;
    logic [IDX_W-1:0]     rr_ptr, rr_ptr_d;
    logic [CNT_W-1:0]     cnt, cnt_d;
    logic [IDX_W-1:0]     owner_d;
    logic [NUM_REQ-1:0]   grant_d, done_d;
    logic                 error_d, tx_send_d;
    logic [FRAME_W-1:0]   tx_data_d;
    logic                 sel_valid;
    logic [IDX_W-1:0]     sel_idx;
    logic [IDX_W-1:0]     next_ptr;

    rr_priority_select #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_select (
        .req   (req),
        .ptr   (rr_ptr),
        .valid (sel_valid),
        .idx   (sel_idx)
    );

    // The requester after the owner gets first priority once the frame ends either way.
    assign next_ptr = (owner == IDX_W'(NUM_REQ - 1)) ? '0 : owner + IDX_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ARB_IDLE;
            rr_ptr  <= '0;
            cnt     <= '0;
            owner   <= '0;
            grant   <= '0;
            done    <= '0;
            error   <= 1'b0;
            tx_send <= 1'b0;
            tx_data <= '0;
        end else begin
            state   <= state_d;
            rr_ptr  <= rr_ptr_d;
            cnt     <= cnt_d;
            owner   <= owner_d;
            grant   <= grant_d;
            done    <= done_d;
            error   <= error_d;
            tx_send <= tx_send_d;
            tx_data <= tx_data_d;
        end
    end

    always_comb begin
        state_d   = state;
        rr_ptr_d  = rr_ptr;
        cnt_d     = cnt;
        owner_d   = owner;
        grant_d   = '0;
        done_d    = '0;
        error_d   = 1'b0;
        tx_send_d = tx_send;
        tx_data_d = tx_data;
        case (state)
            ARB_IDLE: begin
                // A busy transmitter here belongs to someone else; never launch over it.
                if (sel_valid && !tx_busy) begin
                    tx_data_d        = req_data[int'(sel_idx)*FRAME_W +: FRAME_W];
                    owner_d          = sel_idx;
                    grant_d[sel_idx] = 1'b1;
                    tx_send_d        = 1'b1;
                    cnt_d            = '0;
                    state_d          = ARB_LAUNCH;
                end
            end
            ARB_LAUNCH: begin
                if (tx_busy) begin
                    tx_send_d = 1'b0;
                    state_d   = ARB_WAIT_DONE;
                end else if (cnt == CNT_W'(START_TIMEOUT - 1)) begin
                    tx_send_d = 1'b0;
                    error_d   = 1'b1;
                    rr_ptr_d  = next_ptr;
                    state_d   = ARB_IDLE;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            ARB_WAIT_DONE: begin
                if (!tx_busy) begin
                    done_d[owner] = 1'b1;
                    rr_ptr_d      = next_ptr;
                    state_d       = ARB_IDLE;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

endmodule
